video_timing: RTL
=================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 The module SHALL declare parameter PIPE_DELAY, default 1: extra gpu_clk cycles of delay on hsync_o/vsync_o/visible_o, to match the downstream registered pixel path.
REQ-002 gpu_clk  input  1  pixel clock, 25.175 MHz nominal; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 current_x_o  output  8  game-pixel column 0..255, consumed by the background and sprite stages.
REQ-005 current_y_o  output  8  game-pixel row 0..239.
REQ-006 visible_o  output  1  high when the current output pixel lies inside the 512x480 game window.
REQ-007 hsync_o  output  1  VGA horizontal sync, active-low.
REQ-008 vsync_o  output  1  VGA vertical sync, active-low.
REQ-009 vblank_o  output  1  high while the raster is in vertical blank; the CPU may write VRAM only while this is high.
REQ-010 vblank_irq_o  output  1  one-cycle pulse at the start of vertical blank.

Function
REQ-011 Horizontal counter h SHALL count 0..799, then wrap to 0.
REQ-012 Vertical counter v SHALL increment only when h wraps, count 0..524, then wrap to 0.
REQ-013 Horizontal timing SHALL be 640 visible, 16 front porch, 96 sync, 48 back porch.
REQ-014 Vertical timing SHALL be 480 visible, 10 front porch, 2 sync, 33 back porch.
REQ-015 The raw window condition is 64<=h<=575 and v<=479; the game window is centred, with 64-pixel left and right borders.
REQ-016 current_x_o SHALL equal (h-64)>>1 when the window condition holds, else 0.
REQ-017 current_x_o SHALL be registered, so the output at cycle t+1 reflects h at cycle t.
REQ-018 current_y_o SHALL equal v>>1 when v<=479, else 0, registered with the same 1-cycle latency as current_x_o.
REQ-019 The raw hsync level SHALL be low when 656<=h<=751.
REQ-020 The raw vsync level SHALL be low when 490<=v<=491.
REQ-021 hsync_o, vsync_o and visible_o SHALL carry the raw hsync level, the raw vsync level and the window condition, with a total latency of 1+PIPE_DELAY cycles from the counters.
REQ-022 With PIPE_DELAY=0, hsync_o, vsync_o and visible_o SHALL align with current_x_o and current_y_o.
REQ-023 vblank_o SHALL be high, registered (1-cycle latency), exactly while v>=480.
REQ-024 vblank_irq_o SHALL pulse high for exactly one cycle, registered, for the counter state (h=0, v=480): once per frame, every 420000 cycles.
REQ-025 Wrap boundaries: at (h=799, v=524) the next state SHALL be (0,0), and vblank_o SHALL drop one cycle later.
REQ-026 There are no other inputs, so no simultaneous-event cases exist beyond counter wraps.

Reset
REQ-027 On rst_n low, h and v SHALL immediately become 0.
REQ-028 On rst_n low, the outputs SHALL immediately take these values: current_x_o=0, current_y_o=0, visible_o=0, hsync_o=1, vsync_o=1, vblank_o=0, vblank_irq_o=0.
REQ-029 On rst_n low, every stage of the PIPE_DELAY line SHALL load its inactive value: sync stages 1, visible stages 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; no vblank_irq_o pulse SHALL be produced for the aborted frame.
REQ-031 After rst_n deasserts, the first posedge SHALL count from (0,0).

Structure
REQ-032 The screen constants (256, 240) and the eight VGA timing constants SHALL live in the shared mapache64 package as localparams.
REQ-033 The PIPE_DELAY shift register SHALL be a sub-module, video_delay, parameterised by width, depth and reset value.
REQ-034 video_delay with depth 0 SHALL be a pure wire.

Verification
REQ-035 Release reset, count 800 cycles -> hsync_o low for exactly 96 consecutive cycles, first low at cycle 657+PIPE_DELAY after release.
REQ-036 Run 2 frames -> vblank_irq_o pulses exactly twice, 420000 cycles apart; vblank_o is high for 45*800=36000 cycles per frame.
REQ-037 Sample at h=64, v=0 -> next cycle current_x_o=0, current_y_o=0; at h=575, v=479 -> current_x_o=255, current_y_o=239.
REQ-038 Line 100 -> visible_o high for exactly 512 cycles, and current_x_o increments every 2 cycles 0..255.
REQ-039 Assert rst_n at v=300 -> all outputs reach their reset values without a clock edge; after release, next vblank_irq_o arrives 480*800+1 cycles later.
REQ-040 Run with PIPE_DELAY=0 and PIPE_DELAY=3 -> the hsync_o falling edge shifts by exactly 3 cycles; current_x_o timing is unchanged.

Source files
------------

// File: rtl/mapache64_pkg.sv
// Shared mapache64 constants: game screen size, VGA 640x480@60 raster timing
// and small helpers for mapping raster positions onto the 2x-scaled game window.
package mapache64_pkg;

    typedef logic [9:0] hcount_t;
    typedef logic [9:0] vcount_t;

    localparam logic [9:0] SCREEN_W  = 10'd256;
    localparam logic [9:0] SCREEN_H  = 10'd240;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;

    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    // Game pixels are doubled, so the 512-wide window leaves equal side borders.
    localparam logic [9:0] H_BORDER  = (H_VISIBLE - (SCREEN_W << 1)) >> 1;
    localparam logic [9:0] WIN_X_END = H_BORDER + (SCREEN_W << 1) - 10'd1;
    localparam logic [9:0] V_WIN_END = (SCREEN_H << 1) - 10'd1;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic visible;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, visible: 1'b0};

    function automatic logic in_window(input hcount_t h, input vcount_t v);
        return (h >= H_BORDER) && (h <= WIN_X_END) && (v <= V_WIN_END);
    endfunction

    function automatic logic [7:0] game_x(input hcount_t h);
        hcount_t offs;
        offs = h - H_BORDER;
        return offs[8:1];
    endfunction

endpackage

// File: rtl/video_delay.sv
// Reset-initialised shift register of configurable width and depth; depth 0
// degenerates to a plain wire.
module video_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk_i ^ rst_ni;
            assign data_o           = data_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Every stage resets to the idle value so nothing active leaks out after reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing.sv
// VGA 800x525 raster generator that maps a 256x240 game screen, doubled in
// both axes, into the centre of the 640x480 visible area.
module video_timing
    import mapache64_pkg::*;
#(
    parameter int PIPE_DELAY = 1
) (
    input  logic       gpu_clk,
    input  logic       rst_n,
    output logic [7:0] current_x_o,
    output logic [7:0] current_y_o,
    output logic       visible_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       vblank_o,
    output logic       vblank_irq_o
);

    hcount_t    h_q, h_d;
    vcount_t    v_q, v_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       vblank_q, vblank_d;
    logic       irq_q, irq_d;
    sync_t      sync_q, sync_d;
    sync_t      sync_dly_s;

    // Raster counter next state: h wraps every line, v advances only on that wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_TOTAL - 10'd1) begin
            h_d = 10'd0;
            if (v_q == V_TOTAL - 10'd1) begin
                v_d = 10'd0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    // Decode the current raster position into next-cycle output values.
    always_comb begin
        x_d      = 8'd0;
        y_d      = 8'd0;
        sync_d   = SYNC_IDLE;
        vblank_d = 1'b0;
        irq_d    = 1'b0;
        if (in_window(h_q, v_q)) begin
            x_d = game_x(h_q);
        end else begin
            x_d = 8'd0;
        end
        if (v_q <= V_WIN_END) begin
            y_d = v_q[8:1];
        end else begin
            y_d = 8'd0;
        end
        sync_d.hsync_n = ~((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
        sync_d.vsync_n = ~((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
        sync_d.visible = in_window(h_q, v_q);
        vblank_d       = (v_q >= V_VISIBLE);
        irq_d          = (h_q == 10'd0) && (v_q == V_VISIBLE);
    end

    // Counters and first output register stage; reset aborts the frame in progress.
    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            x_q      <= 8'd0;
            y_q      <= 8'd0;
            sync_q   <= SYNC_IDLE;
            vblank_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sync_q   <= sync_d;
            vblank_q <= vblank_d;
            irq_q    <= irq_d;
        end
    end

    video_delay #(
        .WIDTH    ($bits(sync_t)),
        .DEPTH    (PIPE_DELAY),
        .RESET_VAL(SYNC_IDLE)
    ) u_sync_delay (
        .clk_i (gpu_clk),
        .rst_ni(rst_n),
        .data_i(sync_q),
        .data_o(sync_dly_s)
    );

    assign current_x_o  = x_q;
    assign current_y_o  = y_q;
    assign visible_o    = sync_dly_s.visible;
    assign hsync_o      = sync_dly_s.hsync_n;
    assign vsync_o      = sync_dly_s.vsync_n;
    assign vblank_o     = vblank_q;
    assign vblank_irq_o = irq_q;

endmodule
